cmd_arbiter: RTL and testbench
==============================

CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 24'd10_000_000, meaning cycles allowed from command issue to cp_send_resp.
REQ-002 SHALL have parameter TW, default 24, meaning watchdog counter width.
REQ-003 clk  in  1  system clock; single clock domain, all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rmt_cmd  in  16  remote command word from the UART wrapper; rmt_cmd_rdy  in  1  remote command valid (level).
REQ-006 rmt_clr_cmd_rdy  out  1  one-cycle pulse; remote command absorbed.
REQ-007 tour_usurp  in  1  tour sequencer requests ownership; tour_cmd  in  16; tour_cmd_rdy  in  1; tour_resp  in  8  response code for the tour command in flight.
REQ-008 tour_clr_cmd_rdy  out  1; tour_send_resp  out  1  one-cycle pulse; tour command completed.
REQ-009 cp_cmd  out  16; cp_cmd_rdy  out  1  command to cmd_proc; cp_clr_cmd_rdy  in  1; cp_send_resp  in  1  cmd_proc completion pulse.
REQ-010 trmt  out  1  one-cycle transmit pulse; resp  out  8  response byte; tx_done  in  1  UART transmit complete.
REQ-011 owner  out  2  00 none, 01 remote, 10 tour; timeout  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-012 States SHALL be IDLE, RMT_ACT, RMT_TX, TOUR_ACT, TOUR_TX.
REQ-013 One-entry remote buffer: when rmt_cmd_rdy=1 and pend_vld=0, latch rmt_cmd and set pend_vld; pulse rmt_clr_cmd_rdy in the same cycle (Mealy).
REQ-014 If pend_vld=1, rmt_cmd_rdy SHALL be left unconsumed (backpressure). No command is dropped.
REQ-015 IDLE: tour_usurp=1 -> TOUR_ACT (tour wins a simultaneous request). Else pend_vld=1 -> RMT_ACT.
REQ-016 RMT_ACT: cp_cmd=pend and cp_cmd_rdy=pend_vld; cp_clr_cmd_rdy clears pend_vld; cp_send_resp -> RMT_TX with resp=8'hA5 and trmt pulsed on entry.
REQ-017 TOUR_ACT: cp_cmd=tour_cmd, cp_cmd_rdy=tour_cmd_rdy, tour_clr_cmd_rdy=cp_clr_cmd_rdy, tour_send_resp=cp_send_resp.
REQ-018 On cp_send_resp in TOUR_ACT: go to TOUR_TX with resp=tour_resp and pulse trmt.
REQ-019 RMT_TX: on tx_done -> IDLE. TOUR_TX: on tx_done -> TOUR_ACT if tour_usurp=1, else IDLE.
REQ-020 No preemption. A usurp arriving during RMT_ACT/RMT_TX waits; remote commands arriving during the tour are buffered and served after release.
REQ-021 outstanding flag: set on cp_clr_cmd_rdy in an ACT state, cleared on cp_send_resp.
REQ-022 tour_usurp falling in TOUR_ACT -> IDLE only if outstanding=0; otherwise complete the command first.
REQ-023 Watchdog: clears on ACT-state entry, cp_clr_cmd_rdy and cp_send_resp; counts in ACT states while outstanding=1.
REQ-024 Watchdog expiry at TIMEOUT_CYC: pulse timeout, clear outstanding, go to RMT_TX (from RMT_ACT) or TOUR_TX (from TOUR_ACT) with resp=8'hEE and trmt pulsed; tour_send_resp not pulsed.
REQ-025 Whenever state is not an ACT state, cp_cmd_rdy=0 and tour_clr_cmd_rdy=0.
REQ-026 owner SHALL be 01 in RMT_*, 10 in TOUR_*, 00 in IDLE.

Reset
REQ-027 rst=1 at any time, including mid-command or mid-transmit, SHALL force state IDLE; clear pend_vld, outstanding and watchdog; set cp_cmd=0, resp=0; drive all pulse outputs to 0 and owner=00 on the next edge.

Structure
REQ-028 Shared package knight_pkg SHALL hold arb_state_t, RESP_ACK=8'hA5, RESP_TOUR_MID=8'h5A, RESP_TIMEOUT=8'hEE, and the OWNER_NONE/RMT/TOUR constants.
REQ-029 One sub-module SHALL be resp_watchdog (TW-bit counter with clear, enable and expire).
REQ-030 The block SHALL sit between UART_wrapper/TourCmd and cmd_proc in KnightsTour.

Verification
REQ-031 Remote 16'h0000 after reset -> cp_cmd=16'h0000, cp_cmd_rdy=1, owner=01; cp_send_resp -> trmt with resp=8'hA5; tx_done -> owner=00.
REQ-032 tour_usurp and rmt_cmd_rdy (16'h4022) rise in the same cycle -> owner=10 and tour_cmd is forwarded; 16'h4022 is held in pend. After usurp drops and TOUR_TX completes, 16'h4022 is issued with owner=01.
REQ-033 Tour move with tour_resp=8'h5A then 8'hA5 -> two trmt pulses with resp 5A then A5; tour_send_resp pulses once per cmd_proc completion.
REQ-034 Second remote command while pend_vld=1 -> rmt_clr_cmd_rdy stays 0 until the first is cleared by cmd_proc, then pulses once.
REQ-035 TIMEOUT_CYC=100, cp_clr_cmd_rdy with no cp_send_resp -> timeout pulses exactly 100 cycles later and resp=8'hEE; state returns IDLE after tx_done.
REQ-036 rst asserted during TOUR_TX -> next cycle owner=00, trmt=0, pend_vld=0; a new remote command is serviced normally afterwards.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared types and constants for the KnightsTour command path.
// Used by the command arbiter and the blocks around it.
package knight_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RMT_ACT,
        RMT_TX,
        TOUR_ACT,
        TOUR_TX
    } arb_state_t;

    localparam logic [7:0] RESP_ACK      = 8'hA5;
    localparam logic [7:0] RESP_TOUR_MID = 8'h5A;
    localparam logic [7:0] RESP_TIMEOUT  = 8'hEE;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_RMT  = 2'b01;
    localparam logic [1:0] OWNER_TOUR = 2'b10;

endpackage

// File: rtl/resp_watchdog.sv
// Response watchdog: counts enabled cycles since the last clear.
// expire flags the cycle whose edge would complete LIMIT counted cycles.
module resp_watchdog #(
    parameter int unsigned   TW    = 24,
    parameter logic [TW-1:0] LIMIT = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TW-1:0] One = TW'(1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + One;
        end
    end

    // A clear in the same cycle (completion or new accept) beats expiry.
    assign expire = en && !clr && (cnt == LIMIT - One);

endmodule

// File: rtl/cmd_arbiter.sv
// Arbitrates cmd_proc between the remote UART command path and the tour sequencer.
// Remote commands are buffered one deep; the tour keeps ownership until it releases.
module cmd_arbiter
    import knight_pkg::*;
#(
    parameter int unsigned   TW          = 24,
    parameter logic [TW-1:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rmt_cmd,
    input  logic        rmt_cmd_rdy,
    output logic        rmt_clr_cmd_rdy,
    input  logic        tour_usurp,
    input  logic [15:0] tour_cmd,
    input  logic        tour_cmd_rdy,
    input  logic [7:0]  tour_resp,
    output logic        tour_clr_cmd_rdy,
    output logic        tour_send_resp,
    output logic [15:0] cp_cmd,
    output logic        cp_cmd_rdy,
    input  logic        cp_clr_cmd_rdy,
    input  logic        cp_send_resp,
    output logic        trmt,
    output logic [7:0]  resp,
    input  logic        tx_done,
    output logic [1:0]  owner,
    output logic        timeout
);

    arb_state_t  state;
    logic [15:0] pend;
    logic        pend_vld;
    logic        outstanding;
    logic        in_act;
    logic        wd_clr;
    logic        wd_en;
    logic        wd_expire;

    assign in_act = (state == RMT_ACT) || (state == TOUR_ACT);
    // Holding the counter clear outside ACT states clears it on every ACT entry.
    assign wd_clr = !in_act || cp_clr_cmd_rdy || cp_send_resp;
    assign wd_en  = in_act && outstanding;

    resp_watchdog #(
        .TW    (TW),
        .LIMIT (TIMEOUT_CYC)
    ) u_resp_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    assign rmt_clr_cmd_rdy = rmt_cmd_rdy && !pend_vld && !rst;

    always_comb begin
        cp_cmd           = '0;
        cp_cmd_rdy       = 1'b0;
        tour_clr_cmd_rdy = 1'b0;
        tour_send_resp   = 1'b0;
        owner            = OWNER_NONE;
        unique case (state)
            RMT_ACT: begin
                cp_cmd     = pend;
                // The buffer may refill with the next command while this one runs.
                cp_cmd_rdy = pend_vld && !outstanding;
                owner      = OWNER_RMT;
            end
            RMT_TX: owner = OWNER_RMT;
            TOUR_ACT: begin
                cp_cmd           = tour_cmd;
                cp_cmd_rdy       = tour_cmd_rdy;
                tour_clr_cmd_rdy = cp_clr_cmd_rdy;
                tour_send_resp   = cp_send_resp;
                owner            = OWNER_TOUR;
            end
            TOUR_TX: owner = OWNER_TOUR;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            pend_vld    <= 1'b0;
            outstanding <= 1'b0;
            resp        <= '0;
            trmt        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            trmt    <= 1'b0;
            timeout <= 1'b0;

            if (state == RMT_ACT && cp_cmd_rdy && cp_clr_cmd_rdy) begin
                pend_vld <= 1'b0;
            end
            if (rmt_clr_cmd_rdy) begin
                pend     <= rmt_cmd;
                pend_vld <= 1'b1;
            end

            if (in_act && cp_clr_cmd_rdy) begin
                outstanding <= 1'b1;
            end
            if (cp_send_resp || wd_expire) begin
                outstanding <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (tour_usurp) begin
                        state <= TOUR_ACT;
                    end else if (pend_vld) begin
                        state <= RMT_ACT;
                    end
                end
                RMT_ACT: begin
                    if (wd_expire) begin
                        state   <= RMT_TX;
                        resp    <= RESP_TIMEOUT;
                        trmt    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (cp_send_resp) begin
                        state <= RMT_TX;
                        resp  <= RESP_ACK;
                        trmt  <= 1'b1;
                    end
                end
                RMT_TX: begin
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end
                TOUR_ACT: begin
                    if (wd_expire) begin
                        state   <= TOUR_TX;
                        resp    <= RESP_TIMEOUT;
                        trmt    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (cp_send_resp) begin
                        state <= TOUR_TX;
                        resp  <= tour_resp;
                        trmt  <= 1'b1;
                    end else if (!tour_usurp && !outstanding && !cp_clr_cmd_rdy) begin
                        state <= IDLE;
                    end
                end
                TOUR_TX: begin
                    if (tx_done) begin
                        state <= tour_usurp ? TOUR_ACT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: remote path, tour ownership, backpressure,
// watchdog expiry and reset during a tour transmit.
module tb_cmd_arbiter;
    import knight_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] rmt_cmd;
    logic        rmt_cmd_rdy;
    logic        rmt_clr_cmd_rdy;
    logic        tour_usurp;
    logic [15:0] tour_cmd;
    logic        tour_cmd_rdy;
    logic [7:0]  tour_resp;
    logic        tour_clr_cmd_rdy;
    logic        tour_send_resp;
    logic [15:0] cp_cmd;
    logic        cp_cmd_rdy;
    logic        cp_clr_cmd_rdy;
    logic        cp_send_resp;
    logic        trmt;
    logic [7:0]  resp;
    logic        tx_done;
    logic [1:0]  owner;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    cmd_arbiter #(
        .TW          (24),
        .TIMEOUT_CYC (24'd100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rmt_cmd          (rmt_cmd),
        .rmt_cmd_rdy      (rmt_cmd_rdy),
        .rmt_clr_cmd_rdy  (rmt_clr_cmd_rdy),
        .tour_usurp       (tour_usurp),
        .tour_cmd         (tour_cmd),
        .tour_cmd_rdy     (tour_cmd_rdy),
        .tour_resp        (tour_resp),
        .tour_clr_cmd_rdy (tour_clr_cmd_rdy),
        .tour_send_resp   (tour_send_resp),
        .cp_cmd           (cp_cmd),
        .cp_cmd_rdy       (cp_cmd_rdy),
        .cp_clr_cmd_rdy   (cp_clr_cmd_rdy),
        .cp_send_resp     (cp_send_resp),
        .trmt             (trmt),
        .resp             (resp),
        .tx_done          (tx_done),
        .owner            (owner),
        .timeout          (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cp_accept();
        cp_clr_cmd_rdy = 1'b1;
        tick();
        cp_clr_cmd_rdy = 1'b0;
        #1;
    endtask

    task automatic cp_done();
        cp_send_resp = 1'b1;
        tick();
        cp_send_resp = 1'b0;
        #1;
    endtask

    task automatic tx_finish();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got expired, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int early;
        rst = 1'b1;
        rmt_cmd = '0;
        rmt_cmd_rdy = 1'b0;
        tour_usurp = 1'b0;
        tour_cmd = '0;
        tour_cmd_rdy = 1'b0;
        tour_resp = '0;
        cp_clr_cmd_rdy = 1'b0;
        cp_send_resp = 1'b0;
        tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_owner", owner, 2'b00);
        check_eq("rst_trmt", trmt, 1'b0);
        check_eq("rst_cp_rdy", cp_cmd_rdy, 1'b0);
        check_eq("rst_cp_cmd", cp_cmd, 16'h0000);
        check_eq("rst_resp", resp, 8'h00);
        check_eq("rst_timeout", timeout, 1'b0);

        // Plain remote command
        rmt_cmd = 16'h0000;
        rmt_cmd_rdy = 1'b1;
        #1;
        check_eq("r1_clr_pulse", rmt_clr_cmd_rdy, 1'b1);
        tick();
        rmt_cmd_rdy = 1'b0;
        tick();
        check_eq("r1_owner", owner, 2'b01);
        check_eq("r1_cp_rdy", cp_cmd_rdy, 1'b1);
        check_eq("r1_cp_cmd", cp_cmd, 16'h0000);
        cp_accept();
        check_eq("r1_rdy_after_clr", cp_cmd_rdy, 1'b0);
        cp_send_resp = 1'b1;
        #1;
        check_eq("r1_no_tour_resp", tour_send_resp, 1'b0);
        tick();
        cp_send_resp = 1'b0;
        #1;
        check_eq("r1_trmt", trmt, 1'b1);
        check_eq("r1_resp", resp, 8'hA5);
        tick();
        check_eq("r1_trmt_pulse", trmt, 1'b0);
        tx_finish();
        check_eq("r1_owner_done", owner, 2'b00);

        // Simultaneous usurp and remote request: tour wins, remote buffered
        tour_usurp = 1'b1;
        tour_cmd = 16'h1234;
        tour_cmd_rdy = 1'b1;
        rmt_cmd = 16'h4022;
        rmt_cmd_rdy = 1'b1;
        #1;
        check_eq("t_rmt_absorb", rmt_clr_cmd_rdy, 1'b1);
        tick();
        rmt_cmd_rdy = 1'b0;
        #1;
        check_eq("t_owner", owner, 2'b10);
        check_eq("t_cp_cmd", cp_cmd, 16'h1234);
        check_eq("t_cp_rdy", cp_cmd_rdy, 1'b1);
        cp_clr_cmd_rdy = 1'b1;
        #1;
        check_eq("t_tour_clr", tour_clr_cmd_rdy, 1'b1);
        tick();
        cp_clr_cmd_rdy = 1'b0;
        tour_cmd_rdy = 1'b0;
        tour_resp = RESP_TOUR_MID;
        cp_send_resp = 1'b1;
        #1;
        check_eq("t_send_resp1", tour_send_resp, 1'b1);
        tick();
        cp_send_resp = 1'b0;
        #1;
        check_eq("t_trmt1", trmt, 1'b1);
        check_eq("t_resp1", resp, 8'h5A);
        check_eq("t_send_resp1_once", tour_send_resp, 1'b0);
        tx_finish();
        check_eq("t_owner_back", owner, 2'b10);
        tour_cmd = 16'h2345;
        tour_cmd_rdy = 1'b1;
        #1;
        check_eq("t_cp_cmd2", cp_cmd, 16'h2345);
        cp_accept();
        tour_cmd_rdy = 1'b0;
        // Release with a command outstanding: ownership must hold
        tour_usurp = 1'b0;
        tick();
        check_eq("t_hold_outstanding", owner, 2'b10);
        tour_resp = 8'hA5;
        cp_send_resp = 1'b1;
        #1;
        check_eq("t_send_resp2", tour_send_resp, 1'b1);
        tick();
        cp_send_resp = 1'b0;
        #1;
        check_eq("t_trmt2", trmt, 1'b1);
        check_eq("t_resp2", resp, 8'hA5);
        tx_finish();
        check_eq("t_release", owner, 2'b00);
        tick();
        check_eq("t_pend_owner", owner, 2'b01);
        check_eq("t_pend_cmd", cp_cmd, 16'h4022);
        check_eq("t_pend_rdy", cp_cmd_rdy, 1'b1);
        cp_accept();
        cp_done();
        tx_finish();

        // Backpressure on a second remote command
        rmt_cmd = 16'h1111;
        rmt_cmd_rdy = 1'b1;
        tick();
        rmt_cmd = 16'h2222;
        #1;
        check_eq("bp_hold1", rmt_clr_cmd_rdy, 1'b0);
        tick();
        check_eq("bp_hold2", rmt_clr_cmd_rdy, 1'b0);
        check_eq("bp_cmd1", cp_cmd, 16'h1111);
        cp_clr_cmd_rdy = 1'b1;
        #1;
        check_eq("bp_hold3", rmt_clr_cmd_rdy, 1'b0);
        tick();
        cp_clr_cmd_rdy = 1'b0;
        #1;
        check_eq("bp_release", rmt_clr_cmd_rdy, 1'b1);
        tick();
        rmt_cmd_rdy = 1'b0;
        #1;
        check_eq("bp_once", rmt_clr_cmd_rdy, 1'b0);
        check_eq("bp_no_reoffer", cp_cmd_rdy, 1'b0);
        cp_done();
        check_eq("bp_resp", resp, 8'hA5);
        tx_finish();
        tick();
        check_eq("bp_cmd2", cp_cmd, 16'h2222);
        check_eq("bp_rdy2", cp_cmd_rdy, 1'b1);
        cp_accept();
        cp_done();
        tx_finish();

        // Watchdog expiry
        rmt_cmd = 16'h0777;
        rmt_cmd_rdy = 1'b1;
        tick();
        rmt_cmd_rdy = 1'b0;
        tick();
        cp_accept();
        early = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (timeout !== 1'b0) early++;
        end
        check_eq("wd_early", early, 0);
        tick();
        check_eq("wd_timeout", timeout, 1'b1);
        check_eq("wd_trmt", trmt, 1'b1);
        check_eq("wd_resp", resp, 8'hEE);
        check_eq("wd_owner", owner, 2'b01);
        tick();
        check_eq("wd_pulse", timeout, 1'b0);
        tx_finish();
        check_eq("wd_idle", owner, 2'b00);

        // Reset during tour transmit with a remote command buffered
        tour_usurp = 1'b1;
        tour_cmd = 16'h3333;
        tour_cmd_rdy = 1'b1;
        tick();
        rmt_cmd = 16'h0555;
        rmt_cmd_rdy = 1'b1;
        tick();
        rmt_cmd_rdy = 1'b0;
        cp_accept();
        tour_cmd_rdy = 1'b0;
        tour_resp = RESP_TOUR_MID;
        cp_done();
        check_eq("rx_trmt", trmt, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("rx_owner", owner, 2'b00);
        check_eq("rx_trmt0", trmt, 1'b0);
        check_eq("rx_resp0", resp, 8'h00);
        rst = 1'b0;
        tour_usurp = 1'b0;
        tick();
        tick();
        check_eq("rx_pend_cleared", owner, 2'b00);
        rmt_cmd = 16'h0999;
        rmt_cmd_rdy = 1'b1;
        tick();
        rmt_cmd_rdy = 1'b0;
        tick();
        check_eq("rx_new_owner", owner, 2'b01);
        check_eq("rx_new_cmd", cp_cmd, 16'h0999);
        check_eq("rx_new_rdy", cp_cmd_rdy, 1'b1);
        cp_accept();
        cp_done();
        check_eq("rx_new_resp", resp, 8'hA5);
        tx_finish();
        check_eq("rx_new_done", owner, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
